// File: rtl/headgen_microcode_seq.sv
// headgen_microcode_seq: upstream sequencer for the header-generator output mux.
// Holds a writable 9-bit microcode store (bit 8 = dyn/static select, bits 7:0 =
// static byte or dyn index in bits 1:0). An accepted start snapshots four
// dynamic bytes and streams HDR_LEN words over a valid/ready handshake.
// Optional build macro HEADGEN_SEQ_RUNTIME_LEN_EN adds hdr_len_in, a per-header
// length captured on the accepted start (0 rejects the start, values above the
// store depth saturate to the depth).
module headgen_microcode_seq #(
    parameter int HDR_LEN = 18,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [8:0]        cfg_data,
    output logic              cfg_err,
    input  logic              start,
    input  logic [7:0]        dyn_in_0,
    input  logic [7:0]        dyn_in_1,
    input  logic [7:0]        dyn_in_2,
    input  logic [7:0]        dyn_in_3,
`ifdef HEADGEN_SEQ_RUNTIME_LEN_EN
    input  logic [ADDR_W:0]   hdr_len_in,
`endif
    output logic [7:0]        dyn_hold_0,
    output logic [7:0]        dyn_hold_1,
    output logic [7:0]        dyn_hold_2,
    output logic [7:0]        dyn_hold_3,
    output logic [8:0]        microcode_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [8:0]        store [DEPTH];
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic [ADDR_W-1:0] last_idx;
    logic [ADDR_W-1:0] start_last;
    logic              zero_len;
    logic              beat;
    logic              write_ok;
    logic [8:0]        word0;
    logic [8:0]        word_next;

`ifdef HEADGEN_SEQ_RUNTIME_LEN_EN
    logic [ADDR_W:0]   len_sat;

    // Clamp the requested length to the store depth and derive the final index.
    always_comb begin
        len_sat    = (hdr_len_in > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : hdr_len_in;
        zero_len   = (hdr_len_in == '0);
        start_last = ADDR_W'(len_sat - 1'b1);
    end
`else
    // Fixed header length: the final word index is a constant.
    always_comb begin
        zero_len   = 1'b0;
        start_last = ADDR_W'(HDR_LEN - 1);
    end
`endif

    // Handshake decode and the two combinational store reads feeding microcode_out.
    always_comb begin
        ptr_next  = ptr + 1'b1;
        beat      = out_valid & out_ready;
        write_ok  = cfg_we & (state == IDLE);
        // A same-cycle write to address 0 must be visible in word 0.
        word0     = (write_ok && (cfg_addr == '0)) ? cfg_data : store[0];
        word_next = store[ptr_next];
    end

    // Microcode store: writable only while idle, never reset.
    always_ff @(posedge clk) begin
        if (write_ok) begin
            store[cfg_addr] <= cfg_data;
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            last_idx      <= '0;
            dyn_hold_0    <= '0;
            dyn_hold_1    <= '0;
            dyn_hold_2    <= '0;
            dyn_hold_3    <= '0;
            microcode_out <= '0;
            out_valid     <= 1'b0;
            out_first     <= 1'b0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= cfg_we & (state == RUN);
            case (state)
                IDLE: begin
                    if (start) begin
                        if (zero_len) begin
                            // Empty header: nothing to stream, just signal completion.
                            done <= 1'b1;
                        end else begin
                            dyn_hold_0    <= dyn_in_0;
                            dyn_hold_1    <= dyn_in_1;
                            dyn_hold_2    <= dyn_in_2;
                            dyn_hold_3    <= dyn_in_3;
                            microcode_out <= word0;
                            out_valid     <= 1'b1;
                            out_first     <= 1'b1;
                            out_last      <= (start_last == '0);
                            ptr           <= '0;
                            last_idx      <= start_last;
                            busy          <= 1'b1;
                            state         <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (beat) begin
                        if (ptr == last_idx) begin
                            out_valid <= 1'b0;
                            out_first <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            microcode_out <= word_next;
                            ptr           <= ptr_next;
                            out_first     <= 1'b0;
                            out_last      <= (ptr_next == last_idx);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_headgen_microcode_seq.sv
// Testbench for headgen_microcode_seq: directed vector table, hand-written
// corner-case sequences and randomized traffic against a queue-based model.
module tb_headgen_microcode_seq;

    localparam int ADDR_W  = 5;
    localparam int HDR_LEN = 18;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [8:0]        cfg_data;
    logic              cfg_err;
    logic              start;
    logic [7:0]        dyn_in_0, dyn_in_1, dyn_in_2, dyn_in_3;
`ifdef HEADGEN_SEQ_RUNTIME_LEN_EN
    logic [ADDR_W:0]   hdr_len_in = (ADDR_W+1)'(HDR_LEN);
`endif
    logic [7:0]        dyn_hold_0, dyn_hold_1, dyn_hold_2, dyn_hold_3;
    logic [8:0]        microcode_out;
    logic              out_valid;
    logic              out_ready;
    logic              out_first;
    logic              out_last;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    headgen_microcode_seq #(.HDR_LEN(HDR_LEN), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .cfg_err       (cfg_err),
        .start         (start),
        .dyn_in_0      (dyn_in_0),
        .dyn_in_1      (dyn_in_1),
        .dyn_in_2      (dyn_in_2),
        .dyn_in_3      (dyn_in_3),
`ifdef HEADGEN_SEQ_RUNTIME_LEN_EN
        .hdr_len_in    (hdr_len_in),
`endif
        .dyn_hold_0    (dyn_hold_0),
        .dyn_hold_1    (dyn_hold_1),
        .dyn_hold_2    (dyn_hold_2),
        .dyn_hold_3    (dyn_hold_3),
        .microcode_out (microcode_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_first     (out_first),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: store contents plus the queue of words still to be sent.
    logic [8:0] mem [DEPTH];
    logic [8:0] q [$];
    logic [8:0] m_word;
    logic [7:0] m_hold [4];
    bit         m_first, m_done, m_err;

    typedef struct {
        bit         start;
        bit         rdy;
        bit         chk;
        bit         e_valid;
        logic [8:0] e_word;
        bit         e_first;
        bit         e_last;
        bit         e_done;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] tword(input int i);
        return (i == 0) ? 9'h1AA : 9'(9'h100 + i);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit         was_busy;
        logic [8:0] tmp;
        if (rst) begin
            q.delete();
            m_word = '0; m_first = 0; m_done = 0; m_err = 0;
            for (int i = 0; i < 4; i++) m_hold[i] = '0;
            return;
        end
        was_busy = (q.size() != 0);
        m_err    = cfg_we && was_busy;
        m_done   = 0;
        if (was_busy) begin
            if (out_ready) begin
                tmp = q.pop_front();
                m_first = 0;
                if (q.size() == 0) m_done = 1;
                else m_word = q[0];
            end
        end else begin
            if (cfg_we) mem[cfg_addr] = cfg_data;
            if (start) begin
                q.delete();
                for (int i = 0; i < HDR_LEN; i++) q.push_back(mem[i]);
                m_word = q[0];
                m_first = 1;
                m_hold[0] = dyn_in_0; m_hold[1] = dyn_in_1;
                m_hold[2] = dyn_in_2; m_hold[3] = dyn_in_3;
            end
        end
    endtask

    task automatic check_model();
        chk("valid", out_valid, q.size() != 0);
        chk("word", microcode_out, m_word);
        chk("first", out_first, m_first);
        chk("last", out_last, q.size() == 1);
        chk("busy", busy, q.size() != 0);
        chk("done", done, m_done);
        chk("cfg_err", cfg_err, m_err);
        chk("hold0", dyn_hold_0, m_hold[0]);
        chk("hold1", dyn_hold_1, m_hold[1]);
        chk("hold2", dyn_hold_2, m_hold[2]);
        chk("hold3", dyn_hold_3, m_hold[3]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle_inputs();
        start = 0; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
    endtask

    task automatic run_until_idle(input string name);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            cycle();
            n++;
        end
        chk({name, "_finished"}, q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int beats;
        int n;
        rst = 1; out_ready = 0;
        dyn_in_0 = 0; dyn_in_1 = 0; dyn_in_2 = 0; dyn_in_3 = 0;
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        m_word = '0;
        for (int i = 0; i < 4; i++) m_hold[i] = '0;

        // Reset
        cycle(); cycle();
        chk("reset_valid", out_valid, 0);
        chk("reset_word", microcode_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 0;

        // Load the whole store
        for (int a = 0; a < DEPTH; a++) begin
            cfg_we = 1; cfg_addr = ADDR_W'(a);
            cfg_data = (a < HDR_LEN) ? tword(a) : 9'($urandom);
            cycle();
        end
        idle_inputs();
        cycle();

        // Directed table: one full header with out_ready held high
        for (int i = 0; i <= HDR_LEN + 1; i++) begin
            vec_t v;
            v.start   = (i == 0);
            v.rdy     = 1;
            v.chk     = 1;
            v.e_valid = (i < HDR_LEN);
            v.e_word  = (i < HDR_LEN) ? tword(i) : 9'h0;
            v.e_first = (i == 0);
            v.e_last  = (i == HDR_LEN - 1);
            v.e_done  = (i == HDR_LEN);
            tbl.push_back(v);
        end
        dyn_in_0 = 8'hA0; dyn_in_1 = 8'hA1; dyn_in_2 = 8'hA2; dyn_in_3 = 8'hA3;
        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].start;
            out_ready = tbl[i].rdy;
            cycle();
            if (tbl[i].chk) begin
                chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_valid);
                if (tbl[i].e_valid) chk($sformatf("tbl%0d_word", i), microcode_out, tbl[i].e_word);
                chk($sformatf("tbl%0d_first", i), out_first, tbl[i].e_first);
                chk($sformatf("tbl%0d_last", i), out_last, tbl[i].e_last);
                chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
            end
        end
        idle_inputs();

        // Backpressure: ready pattern 1,0,0,1,0,0,...
        start = 1; out_ready = 0;
        cycle();
        start = 0;
        beats = 0; n = 0;
        while (q.size() != 0 && n < 200) begin
            out_ready = (n % 3 == 0);
            if (out_valid && out_ready) beats++;
            cycle();
            n++;
        end
        chk("bp_beats", beats, HDR_LEN);
        out_ready = 1;
        cycle();

        // Snapshot: dyn_in changes mid-header must not reach dyn_hold
        dyn_in_0 = 8'h11; dyn_in_1 = 8'h22; dyn_in_2 = 8'h33; dyn_in_3 = 8'h44;
        start = 1;
        cycle();
        start = 0;
        for (int i = 0; i < HDR_LEN + 1; i++) begin
            dyn_in_0 = 8'($urandom); dyn_in_1 = 8'($urandom);
            dyn_in_2 = 8'($urandom); dyn_in_3 = 8'($urandom);
            cycle();
        end
        chk("snap_hold0", dyn_hold_0, 8'h11);
        chk("snap_hold1", dyn_hold_1, 8'h22);
        chk("snap_hold2", dyn_hold_2, 8'h33);
        chk("snap_hold3", dyn_hold_3, 8'h44);

        // Busy protection: start and write at word 5
        start = 1;
        cycle();
        start = 0;
        for (int i = 0; i < 5; i++) cycle();
        chk("busy_word5", microcode_out, tword(5));
        start = 1; cfg_we = 1; cfg_addr = 5'd3; cfg_data = 9'h0F0;
        cycle();
        idle_inputs();
        chk("busy_err_pulse", cfg_err, 1);
        chk("busy_word6", microcode_out, tword(6));
        cycle();
        chk("busy_err_clear", cfg_err, 0);
        run_until_idle("busy");

        // Back-to-back: start on the done cycle
        start = 1;
        cycle();
        start = 0;
        n = 0;
        while (!done && n < 100) begin
            cycle();
            n++;
        end
        chk("b2b_done_seen", done, 1);
        start = 1;
        cycle();
        start = 0;
        chk("b2b_valid", out_valid, 1);
        chk("b2b_first", out_first, 1);
        chk("b2b_word0", microcode_out, tword(0));
        run_until_idle("b2b");

        // Reset at word 7
        start = 1;
        cycle();
        start = 0;
        for (int i = 0; i < 7; i++) cycle();
        chk("rst_word7", microcode_out, tword(7));
        rst = 1;
        cycle();
        rst = 0;
        chk("rst_valid", out_valid, 0);
        chk("rst_word", microcode_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_first", out_first, 0);
        chk("rst_last", out_last, 0);
        chk("rst_hold0", dyn_hold_0, 0);
        cycle();
        chk("rst_no_done", done, 0);
        start = 1;
        cycle();
        start = 0;
        for (int i = 1; i < HDR_LEN; i++) begin
            cycle();
            chk($sformatf("rst_replay%0d", i), microcode_out, tword(i));
        end
        run_until_idle("rst_replay");

        // Write to address 0 together with start
        cfg_we = 1; cfg_addr = '0; cfg_data = 9'h155; start = 1;
        cycle();
        idle_inputs();
        chk("wr0_word0", microcode_out, 9'h155);
        run_until_idle("wr0");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 7) == 0);
            cfg_we    = !rst && ($urandom_range(0, 5) == 0);
            cfg_addr  = ADDR_W'($urandom);
            cfg_data  = 9'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            dyn_in_0  = 8'($urandom); dyn_in_1 = 8'($urandom);
            dyn_in_2  = 8'($urandom); dyn_in_3 = 8'($urandom);
            cycle();
        end
        rst = 0;
        idle_inputs();
        out_ready = 1;
        cycle();
        run_until_idle("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
